// File: rtl/ddr4_phy_pkg.sv
// Shared DDR4 PHY definitions: IOD word geometry, idle lane value and delay-line FSM states.
package ddr4_phy_pkg;

    localparam int IOD_PHASES = 4;
    localparam logic [IOD_PHASES-1:0] CA_IDLE_WORD = 4'hF;

    typedef enum logic [2:0] {
        DLY_IDLE   = 3'd0,
        DLY_SETUP  = 3'd1,
        DLY_MOVE   = 3'd2,
        DLY_SETTLE = 3'd3,
        DLY_LOAD   = 3'd4
    } dly_state_e;

endpackage

// File: rtl/ddr4_ca_dly_ctrl.sv
// Dynamic TX delay-line controller: steps MOVE/DIRECTION/LOAD towards a requested tap and
// tracks the current tap value.
module ddr4_ca_dly_ctrl
    import ddr4_phy_pkg::*;
#(
    parameter int TAP_W       = 8,
    parameter int TAP_MAX     = 255,
    parameter int TAP_DEFAULT = 1,
    parameter int SETTLE_CYC  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [TAP_W-1:0] tap_req_i,
    input  logic             tap_req_valid_i,
    output logic             tap_req_ready_o,
    input  logic             tap_reload_i,
    output logic [TAP_W-1:0] tap_cur_o,
    output logic             tap_done_o,
    output logic             tap_err_o,
    output logic             dly_move_o,
    output logic             dly_dir_o,
    output logic             dly_load_o,
    input  logic             dly_oor_i
);

    localparam logic [TAP_W-1:0] TAP_MAX_V     = TAP_MAX[TAP_W-1:0];
    localparam logic [TAP_W-1:0] TAP_DEFAULT_V = TAP_DEFAULT[TAP_W-1:0];
    localparam logic [3:0]       SETTLE_LAST   = 4'(SETTLE_CYC - 1);

    dly_state_e       state_q;
    logic [TAP_W-1:0] tgt_q;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] tap_step_d;
    logic [TAP_W-1:0] req_clamped;
    logic [3:0]       cnt_q;
    logic             dir_q;
    logic             done_q;
    logic             err_q;
    logic             req_accept;

    // Reload wins over a same-cycle request, so ready drops while it is pending.
    assign tap_req_ready_o = rst_ni && (state_q == DLY_IDLE) && !tap_reload_i;
    assign req_accept      = tap_req_valid_i && tap_req_ready_o;
    assign req_clamped     = (tap_req_i > TAP_MAX_V) ? TAP_MAX_V : tap_req_i;

    always_comb begin
        tap_step_d = tap_q;
        if (dir_q && (tap_q != TAP_MAX_V)) begin
            tap_step_d = tap_q + 1'b1;
        end else if (!dir_q && (tap_q != '0)) begin
            tap_step_d = tap_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DLY_IDLE;
            tgt_q   <= '0;
            tap_q   <= TAP_DEFAULT_V;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DLY_IDLE: begin
                    if (tap_reload_i) begin
                        state_q <= DLY_LOAD;
                    end else if (req_accept) begin
                        tgt_q <= req_clamped;
                        err_q <= 1'b0;
                        if (req_clamped == tap_q) begin
                            done_q <= 1'b1;
                        end else begin
                            dir_q   <= (req_clamped > tap_q);
                            state_q <= DLY_SETUP;
                        end
                    end
                end
                DLY_SETUP: state_q <= DLY_MOVE;
                DLY_MOVE: begin
                    cnt_q   <= '0;
                    state_q <= DLY_SETTLE;
                end
                DLY_SETTLE: begin
                    // An out-of-range report means the step did not land, so the tap is kept.
                    if (dly_oor_i) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DLY_IDLE;
                    end else if (cnt_q == SETTLE_LAST) begin
                        tap_q <= tap_step_d;
                        if (tap_step_d == tgt_q) begin
                            done_q  <= 1'b1;
                            state_q <= DLY_IDLE;
                        end else begin
                            state_q <= DLY_MOVE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DLY_LOAD: begin
                    tap_q   <= TAP_DEFAULT_V;
                    err_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DLY_IDLE;
                end
                default: state_q <= DLY_IDLE;
            endcase
        end
    end

    assign tap_cur_o  = tap_q;
    assign tap_done_o = done_q;
    assign tap_err_o  = err_q;
    assign dly_move_o = (state_q == DLY_MOVE);
    assign dly_load_o = (state_q == DLY_LOAD);
    assign dly_dir_o  = dir_q;

endmodule

// File: rtl/ddr4_ca_lane_tx_ctrl.sv
// Fabric-side driver for one DDR4 CA lane: additive-latency pipeline into the IOD 4:1 TX/OE
// words, plus the lane's dynamic TX delay-line controller.
module ddr4_ca_lane_tx_ctrl
    import ddr4_phy_pkg::*;
#(
    parameter int LAT_MAX     = 7,
    parameter int TAP_W       = 8,
    parameter int TAP_MAX     = 255,
    parameter int TAP_DEFAULT = 1,
    parameter int SETTLE_CYC  = 4
) (
    input  logic                  FAB_CLK,
    input  logic                  ARST_N,
    input  logic                  CMD_VALID,
    input  logic [IOD_PHASES-1:0] CMD_PHASE_N,
    input  logic [2:0]            ADD_LAT,
    input  logic                  CA_OE_EN,
    output logic [IOD_PHASES-1:0] TX_DATA_0,
    output logic [IOD_PHASES-1:0] OE_DATA_0,
    input  logic [TAP_W-1:0]      TAP_REQ,
    input  logic                  TAP_REQ_VALID,
    output logic                  TAP_REQ_READY,
    input  logic                  TAP_RELOAD,
    output logic [TAP_W-1:0]      TAP_CUR,
    output logic                  TAP_DONE,
    output logic                  TAP_ERR,
    output logic                  DELAY_LINE_MOVE_0,
    output logic                  DELAY_LINE_DIRECTION_0,
    output logic                  DELAY_LINE_LOAD_0,
    input  logic                  DELAY_LINE_OUT_OF_RANGE_0
);

    localparam logic [2:0] LAT_MAX_V = 3'(LAT_MAX);

    logic [IOD_PHASES-1:0] word_q;
    logic [IOD_PHASES-1:0] oe_q;
    logic [IOD_PHASES-1:0] word_sr_q [LAT_MAX];
    logic [IOD_PHASES-1:0] oe_sr_q   [LAT_MAX];
    logic [2:0]            lat_sel;

    // Idle phases shift out as deasserted-high so the lane never glitches active.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            word_q <= CA_IDLE_WORD;
            oe_q   <= '0;
            for (int i = 0; i < LAT_MAX; i++) begin
                word_sr_q[i] <= CA_IDLE_WORD;
                oe_sr_q[i]   <= '0;
            end
        end else begin
            word_q       <= CMD_VALID ? CMD_PHASE_N : CA_IDLE_WORD;
            oe_q         <= {IOD_PHASES{CA_OE_EN}};
            word_sr_q[0] <= word_q;
            oe_sr_q[0]   <= oe_q;
            for (int i = 1; i < LAT_MAX; i++) begin
                word_sr_q[i] <= word_sr_q[i-1];
                oe_sr_q[i]   <= oe_sr_q[i-1];
            end
        end
    end

    always_comb begin
        lat_sel   = (ADD_LAT > LAT_MAX_V) ? LAT_MAX_V : ADD_LAT;
        TX_DATA_0 = word_q;
        OE_DATA_0 = oe_q;
        if (lat_sel != 3'd0) begin
            TX_DATA_0 = word_sr_q[lat_sel - 3'd1];
            OE_DATA_0 = oe_sr_q[lat_sel - 3'd1];
        end
    end

    ddr4_ca_dly_ctrl #(
        .TAP_W      (TAP_W),
        .TAP_MAX    (TAP_MAX),
        .TAP_DEFAULT(TAP_DEFAULT),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_dly_ctrl (
        .clk_i          (FAB_CLK),
        .rst_ni         (ARST_N),
        .tap_req_i      (TAP_REQ),
        .tap_req_valid_i(TAP_REQ_VALID),
        .tap_req_ready_o(TAP_REQ_READY),
        .tap_reload_i   (TAP_RELOAD),
        .tap_cur_o      (TAP_CUR),
        .tap_done_o     (TAP_DONE),
        .tap_err_o      (TAP_ERR),
        .dly_move_o     (DELAY_LINE_MOVE_0),
        .dly_dir_o      (DELAY_LINE_DIRECTION_0),
        .dly_load_o     (DELAY_LINE_LOAD_0),
        .dly_oor_i      (DELAY_LINE_OUT_OF_RANGE_0)
    );

endmodule

// File: tb/tb_ddr4_ca_lane_tx_ctrl.sv
// Scoreboard bench for ddr4_ca_lane_tx_ctrl: directed stimulus pushes expected words, tap
// completions, MOVE and LOAD pulses; negedge monitors pop and compare them.
module tb_ddr4_ca_lane_tx_ctrl;

    localparam int SETTLE = 4;

    logic       FAB_CLK;
    logic       ARST_N;
    logic       CMD_VALID;
    logic [3:0] CMD_PHASE_N;
    logic [2:0] ADD_LAT;
    logic       CA_OE_EN;
    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic [7:0] TAP_REQ;
    logic       TAP_REQ_VALID;
    logic       TAP_REQ_READY;
    logic       TAP_RELOAD;
    logic [7:0] TAP_CUR;
    logic       TAP_DONE;
    logic       TAP_ERR;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;

    ddr4_ca_lane_tx_ctrl dut (
        .FAB_CLK                  (FAB_CLK),
        .ARST_N                   (ARST_N),
        .CMD_VALID                (CMD_VALID),
        .CMD_PHASE_N              (CMD_PHASE_N),
        .ADD_LAT                  (ADD_LAT),
        .CA_OE_EN                 (CA_OE_EN),
        .TX_DATA_0                (TX_DATA_0),
        .OE_DATA_0                (OE_DATA_0),
        .TAP_REQ                  (TAP_REQ),
        .TAP_REQ_VALID            (TAP_REQ_VALID),
        .TAP_REQ_READY            (TAP_REQ_READY),
        .TAP_RELOAD               (TAP_RELOAD),
        .TAP_CUR                  (TAP_CUR),
        .TAP_DONE                 (TAP_DONE),
        .TAP_ERR                  (TAP_ERR),
        .DELAY_LINE_MOVE_0        (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0   (DELAY_LINE_DIRECTION_0),
        .DELAY_LINE_LOAD_0        (DELAY_LINE_LOAD_0),
        .DELAY_LINE_OUT_OF_RANGE_0(DELAY_LINE_OUT_OF_RANGE_0)
    );

    // Clock / reset / cycle counter
    int cyc = 0;
    initial begin
        FAB_CLK = 1'b0;
        forever #5 FAB_CLK = ~FAB_CLK;
    end
    always @(posedge FAB_CLK) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // Scoreboard: {cycle, tx, oe}, {cycle, tap, err}, {cycle, dir}, {cycle}
    logic [39:0] exp_data_q[$];
    logic [40:0] exp_tap_q[$];
    logic [32:0] exp_move_q[$];
    logic [31:0] exp_load_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors
    logic [39:0] e_data;
    logic [40:0] e_tap;
    logic [32:0] e_move;
    logic [31:0] e_load;
    always @(negedge FAB_CLK) begin
        if (ARST_N) begin
            if (TX_DATA_0 !== 4'hF) begin
                if (exp_data_q.size() == 0) begin
                    check("data_unexpected", 64'(TX_DATA_0), 64'hF);
                end else begin
                    e_data = exp_data_q.pop_front();
                    check("data_cycle", 64'(cyc), 64'(e_data[39:8]));
                    check("tx_data", 64'(TX_DATA_0), 64'(e_data[7:4]));
                    check("oe_data", 64'(OE_DATA_0), 64'(e_data[3:0]));
                end
            end
            if (TAP_DONE) begin
                if (exp_tap_q.size() == 0) begin
                    check("tap_done_unexpected", 64'(TAP_DONE), 64'h0);
                end else begin
                    e_tap = exp_tap_q.pop_front();
                    check("tap_done_cycle", 64'(cyc), 64'(e_tap[40:9]));
                    check("tap_cur", 64'(TAP_CUR), 64'(e_tap[8:1]));
                    check("tap_err", 64'(TAP_ERR), 64'(e_tap[0]));
                end
            end
            if (DELAY_LINE_MOVE_0) begin
                if (exp_move_q.size() == 0) begin
                    check("move_unexpected", 64'(DELAY_LINE_MOVE_0), 64'h0);
                end else begin
                    e_move = exp_move_q.pop_front();
                    check("move_cycle", 64'(cyc), 64'(e_move[32:1]));
                    check("move_dir", 64'(DELAY_LINE_DIRECTION_0), 64'(e_move[0]));
                end
            end
            if (DELAY_LINE_LOAD_0) begin
                if (exp_load_q.size() == 0) begin
                    check("load_unexpected", 64'(DELAY_LINE_LOAD_0), 64'h0);
                end else begin
                    e_load = exp_load_q.pop_front();
                    check("load_cycle", 64'(cyc), 64'(e_load));
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic [3:0] ph, input logic oe);
        tick();
        CMD_VALID   = v;
        CMD_PHASE_N = ph;
        CA_OE_EN    = oe;
        if (v && (ph != 4'hF)) exp_data_q.push_back({32'(cyc + 1 + lat), ph, {4{oe}}});
    endtask

    task automatic idle_cmds(input int n);
        for (int i = 0; i < n; i++) drive_cmd(1'b0, 4'hF, 1'b1);
    endtask

    task automatic tap_request(input logic [7:0] req, input int n_moves, input logic dir,
                               input int tap_lat, input logic [7:0] exp_tap,
                               input logic exp_err, output int acc);
        int n;
        n = 0;
        tick();
        TAP_REQ       = req;
        TAP_REQ_VALID = 1'b1;
        while (!TAP_REQ_READY && n < 50) begin
            tick();
            n++;
        end
        check("tap_req_ready", 64'(TAP_REQ_READY), 64'h1);
        acc = cyc + 1;
        exp_tap_q.push_back({32'(acc + tap_lat), exp_tap, exp_err});
        for (int i = 0; i < n_moves; i++) exp_move_q.push_back({32'(acc + 1 + i * (1 + SETTLE)), dir});
        tick();
        TAP_REQ_VALID = 1'b0;
    endtask

    task automatic wait_tap_done(input int max_cyc);
        int n;
        n = 0;
        while (exp_tap_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check("tap_done_pending", 64'(exp_tap_q.size()), 64'h0);
        check("move_pending", 64'(exp_move_q.size()), 64'h0);
        exp_tap_q.delete();
        exp_move_q.delete();
    endtask

    int acc;
    int k;

    initial begin
        ARST_N = 1'b0;
        CMD_VALID = 1'b0;
        CMD_PHASE_N = 4'hF;
        ADD_LAT = 3'd0;
        CA_OE_EN = 1'b1;
        TAP_REQ = 8'd0;
        TAP_REQ_VALID = 1'b0;
        TAP_RELOAD = 1'b0;
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_tx", 64'(TX_DATA_0), 64'hF);
        check("rst_oe", 64'(OE_DATA_0), 64'h0);
        check("rst_tap_cur", 64'(TAP_CUR), 64'h1);
        check("rst_move", 64'(DELAY_LINE_MOVE_0), 64'h0);
        check("rst_load", 64'(DELAY_LINE_LOAD_0), 64'h0);
        check("rst_dir", 64'(DELAY_LINE_DIRECTION_0), 64'h0);
        check("rst_done", 64'(TAP_DONE), 64'h0);
        check("rst_err", 64'(TAP_ERR), 64'h0);
        check("rst_ready", 64'(TAP_REQ_READY), 64'h0);
        ARST_N = 1'b1;
        tick();
        check("ready_after_rst", 64'(TAP_REQ_READY), 64'h1);

        // Data path at several additive latencies
        lat = 0; ADD_LAT = 3'd0;
        drive_cmd(1'b1, 4'b1110, 1'b1);
        idle_cmds(10);
        lat = 5; ADD_LAT = 3'd5;
        drive_cmd(1'b1, 4'b0101, 1'b1);
        idle_cmds(10);
        lat = 3; ADD_LAT = 3'd3;
        drive_cmd(1'b1, 4'b1010, 1'b1);
        drive_cmd(1'b1, 4'b0011, 1'b0);
        drive_cmd(1'b1, 4'b0000, 1'b1);
        drive_cmd(1'b0, 4'b0110, 1'b1);
        idle_cmds(10);
        lat = 7; ADD_LAT = 3'd7;
        drive_cmd(1'b1, 4'b0111, 1'b1);
        drive_cmd(1'b1, 4'b1011, 1'b0);
        idle_cmds(12);
        check("data_pending", 64'(exp_data_q.size()), 64'h0);
        lat = 0; ADD_LAT = 3'd0;
        idle_cmds(8);

        // Reset asserted while MOVE is high drops it at once
        tick();
        TAP_REQ = 8'd5;
        TAP_REQ_VALID = 1'b1;
        tick();
        TAP_REQ_VALID = 1'b0;
        tick();
        check("pre_rst_move", 64'(DELAY_LINE_MOVE_0), 64'h1);
        check("pre_rst_dir", 64'(DELAY_LINE_DIRECTION_0), 64'h1);
        #2;
        ARST_N = 1'b0;
        #1;
        check("async_rst_move", 64'(DELAY_LINE_MOVE_0), 64'h0);
        check("async_rst_tap", 64'(TAP_CUR), 64'h1);
        check("async_rst_ready", 64'(TAP_REQ_READY), 64'h0);
        #3;
        ARST_N = 1'b1;
        repeat (3) tick();

        // 1 -> 4: three upward steps
        tap_request(8'd4, 3, 1'b1, 1 + 3 * (1 + SETTLE), 8'd4, 1'b0, acc);
        wait_tap_done(100);

        // 4 -> 0 with out-of-range in the second step's settle window
        tap_request(8'd0, 2, 1'b0, 9, 8'd3, 1'b1, acc);
        while (cyc < acc + 8) tick();
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
        tick();
        DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        wait_tap_done(100);
        check("ready_after_err", 64'(TAP_REQ_READY), 64'h1);
        repeat (3) tick();
        check("err_sticky", 64'(TAP_ERR), 64'h1);
        check("tap_after_err", 64'(TAP_CUR), 64'h3);

        // Reload and request in the same cycle
        tick();
        k = cyc;
        TAP_RELOAD = 1'b1;
        TAP_REQ = 8'd2;
        TAP_REQ_VALID = 1'b1;
        #1;
        check("reload_blocks_ready", 64'(TAP_REQ_READY), 64'h0);
        exp_load_q.push_back(32'(k + 1));
        exp_tap_q.push_back({32'(k + 2), 8'd1, 1'b0});
        tick();
        TAP_RELOAD = 1'b0;
        check("ready_in_load", 64'(TAP_REQ_READY), 64'h0);
        tick();
        check("ready_after_load", 64'(TAP_REQ_READY), 64'h1);
        check("tap_after_load", 64'(TAP_CUR), 64'h1);
        check("err_after_load", 64'(TAP_ERR), 64'h0);
        exp_tap_q.push_back({32'(cyc + 1 + 6), 8'd2, 1'b0});
        exp_move_q.push_back({32'(cyc + 2), 1'b1});
        tick();
        TAP_REQ_VALID = 1'b0;
        wait_tap_done(100);
        check("load_pending", 64'(exp_load_q.size()), 64'h0);

        // Equal request, full-range sweeps and both saturation boundaries
        tap_request(8'd2, 0, 1'b0, 0, 8'd2, 1'b0, acc);
        wait_tap_done(20);
        tap_request(8'd255, 253, 1'b1, 1 + 253 * (1 + SETTLE), 8'd255, 1'b0, acc);
        wait_tap_done(1400);
        tap_request(8'd255, 0, 1'b1, 0, 8'd255, 1'b0, acc);
        wait_tap_done(20);
        tap_request(8'd0, 255, 1'b0, 1 + 255 * (1 + SETTLE), 8'd0, 1'b0, acc);
        wait_tap_done(1400);
        tap_request(8'd0, 0, 1'b0, 0, 8'd0, 1'b0, acc);
        wait_tap_done(20);
        repeat (4) tick();
        check("tap_final", 64'(TAP_CUR), 64'h0);
        check("move_idle_final", 64'(DELAY_LINE_MOVE_0), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
